// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares a single-port data memory between the core load/store
//             port (c_*) and a DMA/debug port (d_*). Issues at most one
//             access per cycle, using round-robin arbitration with a bounded
//             DMA burst lock. Read data is steered back to the requester that
//             issued the read, one cycle after the grant.
//  Ports    : clk, reset (async, active-high)
//             c_req/c_wr/c_addr/c_wdata -> c_gnt/c_rvalid/c_rdata  (core)
//             d_req/d_wr/d_addr/d_wdata/d_lock -> d_gnt/d_rvalid/d_rdata (DMA)
//             m_wr/m_rd/m_addr/m_wdata -> memory macro, m_rdata <- memory
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  // core port
  input  logic              c_req,
  input  logic              c_wr,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  // DMA / debug port
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory macro
  output logic              m_wr,
  output logic              m_rd,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  logic       last_q, last_d;   // last winner: 0 = core, 1 = DMA
  logic [3:0] bcnt_q, bcnt_d;   // consecutive locked DMA grants
  logic       rv_c_q, rv_c_d;   // core read in flight
  logic       rv_d_q, rv_d_d;   // DMA read in flight

  // Grant decision. A lock only matters on a tie; the counter forces the
  // DMA to yield once it has won MAX_BURST locked ties in a row.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (c_req && d_req) begin
      if (d_lock) begin
        if (bcnt_q < BURST_MAX) d_gnt = 1'b1;
        else                    c_gnt = 1'b1;
      end else if (last_q) begin
        c_gnt = 1'b1;
      end else begin
        d_gnt = 1'b1;
      end
    end else if (c_req) begin
      c_gnt = 1'b1;
    end else if (d_req) begin
      d_gnt = 1'b1;
    end
  end

  // Memory drive, muxed from the winner; all zero when idle.
  always_comb begin
    m_wr    = 1'b0;
    m_rd    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (c_gnt) begin
      m_wr    = c_wr;
      m_rd    = ~c_wr;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (d_gnt) begin
      m_wr    = d_wr;
      m_rd    = ~d_wr;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

  // Next-state logic.
  always_comb begin
    last_d = last_q;
    if (c_gnt)      last_d = 1'b0;
    else if (d_gnt) last_d = 1'b1;

    bcnt_d = bcnt_q;
    if (d_gnt && d_lock) begin
      bcnt_d = (bcnt_q >= BURST_MAX) ? BURST_MAX : bcnt_q + 4'd1;
    end else if (c_gnt) begin
      bcnt_d = 4'd0;
    end else if (!d_gnt && !d_lock) begin
      // lock released with no DMA access: the burst is over
      bcnt_d = 4'd0;
    end

    rv_c_d = c_gnt & ~c_wr;
    rv_d_d = d_gnt & ~d_wr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;   // core wins the first tie
      bcnt_q <= 4'd0;
      rv_c_q <= 1'b0;
      rv_d_q <= 1'b0;
    end else begin
      last_q <= last_d;
      bcnt_q <= bcnt_d;
      rv_c_q <= rv_c_d;
      rv_d_q <= rv_d_d;
    end
  end

  // Read return: the memory data is only forwarded to the owner of the
  // read issued on the previous edge; the other side sees zero.
  assign c_rvalid = rv_c_q;
  assign c_rdata  = rv_c_q ? m_rdata : '0;
  assign d_rvalid = rv_d_q;
  assign d_rdata  = rv_d_q ? m_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Self-checking bench for dmem_arbiter. Table of per-cycle
//             vectors plus hand-written burst, reset and tie sequences.
//             A small synchronous memory model supplies m_rdata.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 9;
  localparam int MAX_BURST = 4;

  logic              clk;
  logic              reset;
  logic              c_req, c_wr, c_gnt, c_rvalid;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata;
  logic              d_req, d_wr, d_lock, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              m_wr, m_rd;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_wr(m_wr), .m_rd(m_rd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: write at the grant edge, read data the cycle after m_rd.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] mem_rdata;
  assign m_rdata = mem_rdata;
  always @(posedge clk) begin
    if (reset) begin
      mem[16] <= 32'hDEADBEEF;
      mem[32] <= 32'hCAFEF00D;
    end else begin
      if (m_wr) mem[m_addr] <= m_wdata;
      if (m_rd) mem_rdata   <= mem[m_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic              c_req, c_wr;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              d_req, d_wr, d_lock;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              e_cg, e_dg, e_mwr, e_mrd;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic              e_crv;
    logic [DATA_W-1:0] e_crd;
    logic              e_drv;
    logic [DATA_W-1:0] e_drd;
  } vec_t;

  task automatic drive_idle();
    c_req = 0; c_wr = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_wr = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " c_gnt"},    32'(c_gnt),    32'(v.e_cg));
    chk({tag, " d_gnt"},    32'(d_gnt),    32'(v.e_dg));
    chk({tag, " m_wr"},     32'(m_wr),     32'(v.e_mwr));
    chk({tag, " m_rd"},     32'(m_rd),     32'(v.e_mrd));
    chk({tag, " m_addr"},   32'(m_addr),   32'(v.e_addr));
    chk({tag, " m_wdata"},  m_wdata,       v.e_wdata);
    chk({tag, " c_rvalid"}, 32'(c_rvalid), 32'(v.e_crv));
    chk({tag, " c_rdata"},  c_rdata,       v.e_crd);
    chk({tag, " d_rvalid"}, 32'(d_rvalid), 32'(v.e_drv));
    chk({tag, " d_rdata"},  d_rdata,       v.e_drd);
  endtask

  vec_t vecs [11];

  initial begin
    //           c_req wr addr    wdata          d_req wr lock addr   wdata
    //           cg dg mwr mrd addr  wdata          crv crd           drv drd
    vecs[0]  = '{1,0,9'h010,32'h0,          0,0,0,9'h000,32'h0,
                 1,0,0,1,9'h010,32'h0,          0,32'h0,        0,32'h0};
    vecs[1]  = '{0,0,9'h000,32'h0,          0,0,0,9'h000,32'h0,
                 0,0,0,0,9'h000,32'h0,          1,32'hDEADBEEF, 0,32'h0};
    // ties with last = core: DMA, core, DMA
    vecs[2]  = '{1,0,9'h010,32'hAAAA0000,   1,0,0,9'h020,32'hBBBB0000,
                 0,1,0,1,9'h020,32'hBBBB0000,   0,32'h0,        0,32'h0};
    vecs[3]  = '{1,0,9'h010,32'hAAAA0000,   1,0,0,9'h020,32'hBBBB0000,
                 1,0,0,1,9'h010,32'hAAAA0000,   0,32'h0,        1,32'hCAFEF00D};
    vecs[4]  = '{1,0,9'h010,32'hAAAA0000,   1,0,0,9'h020,32'hBBBB0000,
                 0,1,0,1,9'h020,32'hBBBB0000,   1,32'hDEADBEEF, 0,32'h0};
    // core write, then DMA read of the same word
    vecs[5]  = '{1,1,9'h003,32'h5A5A5A5A,   0,0,0,9'h000,32'h0,
                 1,0,1,0,9'h003,32'h5A5A5A5A,   0,32'h0,        1,32'hCAFEF00D};
    vecs[6]  = '{0,0,9'h000,32'h0,          1,0,0,9'h003,32'h0,
                 0,1,0,1,9'h003,32'h0,          0,32'h0,        0,32'h0};
    vecs[7]  = '{0,0,9'h000,32'h0,          0,0,0,9'h000,32'h0,
                 0,0,0,0,9'h000,32'h0,          0,32'h0,        1,32'h5A5A5A5A};
    // locked DMA write beats a pending core read (bcnt = 0)
    vecs[8]  = '{1,0,9'h010,32'h0,          1,1,1,9'h005,32'h11111111,
                 0,1,1,0,9'h005,32'h11111111,   0,32'h0,        0,32'h0};
    // core changed its address before being granted: new address issued
    vecs[9]  = '{1,0,9'h020,32'h0,          0,0,0,9'h000,32'h0,
                 1,0,0,1,9'h020,32'h0,          0,32'h0,        0,32'h0};
    vecs[10] = '{0,0,9'h000,32'h0,          0,0,0,9'h000,32'h0,
                 0,0,0,0,9'h000,32'h0,          1,32'hCAFEF00D, 0,32'h0};

    // ---------------- reset state ----------------
    drive_idle();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2;
    chk("rst c_rvalid", 32'(c_rvalid), 32'h0);
    chk("rst d_rvalid", 32'(d_rvalid), 32'h0);
    chk("rst c_rdata",  c_rdata,       32'h0);
    chk("rst d_rdata",  d_rdata,       32'h0);
    chk("rst idle gnt", 32'({c_gnt, d_gnt, m_wr, m_rd}), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- table vectors ----------------
    for (int i = 0; i < 11; i++) begin
      c_req = vecs[i].c_req; c_wr = vecs[i].c_wr;
      c_addr = vecs[i].c_addr; c_wdata = vecs[i].c_wdata;
      d_req = vecs[i].d_req; d_wr = vecs[i].d_wr; d_lock = vecs[i].d_lock;
      d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      #2;
      chk_all($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
    end

    // ---------------- locked burst with core waiting ----------------
    for (int k = 0; k < 10; k++) begin
      c_req = 1; c_wr = 0; c_addr = 9'h010; c_wdata = '0;
      d_req = 1; d_wr = 1; d_lock = 1; d_addr = 9'(k + 64); d_wdata = 32'(k);
      #2;
      chk($sformatf("burst%0d c_gnt", k), 32'(c_gnt), 32'((k % 5) == 4));
      chk($sformatf("burst%0d d_gnt", k), 32'(d_gnt), 32'((k % 5) != 4));
      chk($sformatf("burst%0d m_wr", k),  32'(m_wr),  32'((k % 5) != 4));
      chk($sformatf("burst%0d c_rvalid", k), 32'(c_rvalid), 32'(k == 5));
      if (k == 5) chk("burst5 c_rdata", c_rdata, 32'hDEADBEEF);
      @(negedge clk);
    end
    drive_idle();
    #2;
    chk("burst end c_rvalid", 32'(c_rvalid), 32'h1);
    chk("burst end c_rdata",  c_rdata,       32'hDEADBEEF);
    @(negedge clk);

    // ---------------- reset during an in-flight read ----------------
    c_req = 1; c_wr = 0; c_addr = 9'h010;
    #2;
    chk("rstmid c_gnt", 32'(c_gnt), 32'h1);
    @(posedge clk);
    #1;
    drive_idle();
    chk("rstmid pre c_rvalid", 32'(c_rvalid), 32'h1);
    reset = 1'b1;
    #1;
    chk("rstmid c_rvalid", 32'(c_rvalid), 32'h0);
    chk("rstmid c_rdata",  c_rdata,       32'h0);
    @(negedge clk);
    c_req = 1; d_req = 1; c_addr = 9'h010; d_addr = 9'h020;
    #2;
    chk("in-rst tie c_gnt", 32'(c_gnt), 32'h1);
    chk("in-rst tie d_gnt", 32'(d_gnt), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- tie after reset: core, DMA, core, DMA ----------------
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("tie%0d c_gnt", k), 32'(c_gnt), 32'((k % 2) == 0));
      chk($sformatf("tie%0d d_gnt", k), 32'(d_gnt), 32'((k % 2) == 1));
      @(negedge clk);
    end
    drive_idle();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
